// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the unified line-memory port arbiter.
// Contents: word/line sizes, latency counter width, FSM state encoding, owner encoding.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_SIZE  = 16;  // address width
  localparam int unsigned FETCH_SIZE = 64;  // line width (4 words)
  localparam int unsigned CNT_W      = 4;   // holds MEM_LATENCY-1 for latencies up to 15

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arbState_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_latency_timer.sv
// mem_latency_timer: down-counter that times a fixed-latency memory access.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   load          load LATENCY-1 (start of an access)
//   dec           decrement by one while the access is running
//   zero          high when the count has reached 0 (last access cycle)
module mem_latency_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [CNT_W-1:0] LoadVal = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LoadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the I-cache miss path
// (reads) and the D-cache miss/write-back path (reads and writes).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_req/i_addr/i_rdata/i_done  I-cache line-read handshake
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_done  D-cache line read/write handshake
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata  memory port
//   busy                         high whenever not IDLE
// Build option: define MEM_ARB_RR_EN for round-robin tie-break (default: D beats I).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = WORD_SIZE,
  parameter int unsigned LINE_W      = FETCH_SIZE,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'(3);

  arbState_t         state;
  logic              ownerL;
  logic              weL;
  logic [ADDR_W-1:0] addrL;
  logic [LINE_W-1:0] wdataL;

  logic anyReq;
  logic grantOwner;
  logic grantStart;
  logic cntZero;

  assign anyReq     = i_req | d_req;
  assign grantStart = (state == ARB_IDLE) && anyReq;

`ifdef MEM_ARB_RR_EN
  // Side granted most recently; loses the next simultaneous tie.
  logic lastOwner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lastOwner <= OWN_I;
    end else if (grantStart) begin
      lastOwner <= grantOwner;
    end
  end

  always_comb begin
    grantOwner = d_req ? OWN_D : OWN_I;
    if (i_req && d_req) begin
      grantOwner = ~lastOwner;
    end
  end
`else
  // D stalls the pipeline later, so it always wins a tie.
  always_comb begin
    grantOwner = d_req ? OWN_D : OWN_I;
  end
`endif

  mem_latency_timer #(
    .LATENCY (MEM_LATENCY)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grantStart),
    .dec     (state == ARB_ACCESS),
    .zero    (cntZero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      ownerL    <= OWN_I;
      weL       <= 1'b0;
      addrL     <= '0;
      wdataL    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (anyReq) begin
            ownerL <= grantOwner;
            busy   <= 1'b1;
            state  <= ARB_ACCESS;
            if (grantOwner == OWN_D) begin
              addrL     <= d_addr & AddrMask;
              weL       <= d_we;
              wdataL    <= d_wdata;
              mem_read  <= ~d_we;
              mem_write <= d_we;
            end else begin
              addrL     <= i_addr & AddrMask;
              weL       <= 1'b0;
              wdataL    <= '0;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end
        end
        ARB_ACCESS: begin
          if (cntZero) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ARB_RESP;
            if (ownerL == OWN_D) begin
              d_done <= 1'b1;
              if (!weL) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end
        end
        ARB_RESP: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_addr  = addrL;
  assign mem_wdata = mem_write ? wdataL : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic [63:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        busy;

  int nVec = 0;
  int nFail = 0;

  logic [63:0] expIR = '0;
  logic [63:0] expDR = '0;

  mem_port_arbiter #(
    .ADDR_W      (16),
    .LINE_W      (64),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lineFor(input logic [15:0] a);
    if (a == 16'h0124) return 64'h0004_0003_0002_0001;
    return {a, ~a, a ^ 16'h5A5A, 16'h0F0F};
  endfunction

  // Memory model: real data only in the last strobe cycle, filler otherwise.
  int strobeCnt = 0;
  always @(negedge clk) begin
    if (mem_read || mem_write) strobeCnt = strobeCnt + 1;
    else strobeCnt = 0;
    mem_rdata = (mem_read && strobeCnt == LAT) ? lineFor(mem_addr) : 64'h5151_5151_5151_5151;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        isD;
    logic        we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [15:0] expAddr;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v);
    int doneCyc, strobeCyc, otherStrobe, addrBad, wdataBad, both;
    logic rightDone;
    doneCyc = 0; strobeCyc = 0; otherStrobe = 0; addrBad = 0; wdataBad = 0; both = 0;
    rightDone = 1'b0;
    @(negedge clk);
    if (v.isD) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int cyc = 1; cyc <= LAT + 8 && doneCyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        // post-grant input changes must be ignored
        if (v.isD) begin
          d_addr = ~v.addr; d_wdata = ~v.wdata; d_we = ~v.we;
        end else begin
          i_addr = ~v.addr;
        end
      end
      if ((mem_read && mem_write) || (i_done && d_done)) both++;
      if (v.we ? mem_write : mem_read) begin
        strobeCyc++;
        if (mem_addr !== v.expAddr) addrBad++;
        if (mem_wdata !== (v.we ? v.wdata : 64'h0)) wdataBad++;
      end
      if (v.we ? mem_read : mem_write) otherStrobe++;
      if (i_done || d_done) begin
        doneCyc = cyc;
        rightDone = v.isD ? d_done : i_done;
        if (v.isD && !v.we) expDR = lineFor(v.expAddr);
        if (!v.isD) expIR = lineFor(v.expAddr);
        check("i_rdata", i_rdata, expIR);
        check("d_rdata", d_rdata, expDR);
        check("mem_wdata_resp", mem_wdata, 64'h0);
      end
    end
    check("done_latency", doneCyc, LAT + 1);
    check("done_side", rightDone, 1'b1);
    check("strobe_cycles", strobeCyc, LAT);
    check("other_strobe", otherStrobe, 0);
    check("mem_addr", addrBad, 0);
    check("mem_wdata", wdataBad, 0);
    check("exclusive", both, 0);
    @(negedge clk);
    check("busy_idle", busy, 1'b0);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  initial begin
    int dDone, iDone, both, done1, done2, wr, rd, idleCnt, stray;
    logic seenStrobe;
    logic [15:0] firstAddr;
    logic [63:0] dLine, iLine, line;

    vecs[0] = '{1'b0, 1'b0, 16'h0124, 64'h0, 16'h0124};
    vecs[1] = '{1'b0, 1'b0, 16'h0ABF, 64'h0, 16'h0ABC};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 64'h0, 16'h0200};
    vecs[3] = '{1'b1, 1'b1, 16'h0347, 64'hDEAD_BEEF_CAFE_F00D, 16'h0344};
    vecs[4] = '{1'b1, 1'b0, 16'h0003, 64'h0, 16'h0000};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 64'h0, 16'hFFFC};

    // Reset state
    #1;
    check("rst_outputs", {i_done, d_done, mem_read, mem_write, busy}, 5'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_i_rdata", i_rdata, 64'h0);
    check("rst_d_rdata", d_rdata, 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Simultaneous requests: D first, then I after one IDLE cycle
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    dDone = 0; iDone = 0; both = 0; seenStrobe = 1'b0; firstAddr = '0;
    dLine = '0; iLine = '0;
    for (int cyc = 1; cyc <= 3 * LAT + 8 && iDone == 0; cyc++) begin
      @(negedge clk);
      if (dDone != 0 && cyc == dDone + 1) d_req = 1'b0;
      if (mem_read && !seenStrobe) begin
        seenStrobe = 1'b1; firstAddr = mem_addr;
      end
      if ((mem_read && mem_write) || (i_done && d_done)) both++;
      if (d_done) begin dDone = cyc; dLine = d_rdata; end
      if (i_done) begin iDone = cyc; iLine = i_rdata; end
    end
    i_req = 1'b0;
    check("tie_first_addr", firstAddr, 16'h0200);
    check("tie_d_done", dDone, LAT + 1);
    check("tie_i_done", iDone, 2 * LAT + 3);
    check("tie_d_rdata", dLine, lineFor(16'h0200));
    check("tie_i_rdata", iLine, lineFor(16'h0100));
    check("tie_exclusive", both, 0);
    expDR = lineFor(16'h0200);
    expIR = lineFor(16'h0100);
    @(negedge clk);

    // Table-driven single transactions
    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Write-back followed immediately by refill
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 64'h0123_4567_89AB_CDEF;
    done1 = 0; done2 = 0; wr = 0; rd = 0; idleCnt = 0; line = '0;
    for (int cyc = 1; cyc <= 3 * LAT + 10 && done2 == 0; cyc++) begin
      @(negedge clk);
      if (done1 != 0 && cyc == done1 + 1) begin
        d_we = 1'b0; d_addr = 16'h0410;
      end
      if (mem_write) wr++;
      if (mem_read) rd++;
      if (done1 != 0 && !busy) idleCnt++;
      if (d_done) begin
        if (done1 == 0) done1 = cyc;
        else begin
          done2 = cyc; line = d_rdata;
        end
      end
    end
    check("b2b_done1", done1, LAT + 1);
    check("b2b_gap", done2 - done1, LAT + 2);
    check("b2b_writes", wr, LAT);
    check("b2b_reads", rd, LAT);
    check("b2b_idle", idleCnt, 1);
    check("b2b_rdata", line, lineFor(16'h0410));
    expDR = lineFor(16'h0410);
    @(negedge clk);
    d_req = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset in the middle of an access
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0500;
    repeat (2) @(negedge clk);
    check("mid_strobe_on", mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {i_done, d_done, mem_read, mem_write, busy}, 5'b0);
    check("mid_rst_addr", mem_addr, 16'h0);
    i_req = 1'b0; i_addr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    expIR = '0; expDR = '0;
    stray = 0;
    for (int cyc = 0; cyc < 2 * LAT + 4; cyc++) begin
      @(negedge clk);
      if (i_done || d_done || busy || mem_read || mem_write) stray++;
    end
    check("mid_no_stale", stray, 0);
    check("mid_i_rdata", i_rdata, 64'h0);

    // Recovery after reset
    run_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
